// File: rtl/exc_ctrl.sv
// exc_ctrl: LEGv8 exception controller owning ELR/ESR, the take/return FSM and IRQ synchronisation.
// Redirect/flush/irq_ack are decoded from registered state so they are single-cycle and glitch-free.
module exc_ctrl #(
    parameter int             N           = 64,
    parameter logic [N-1:0]   EXC_VECTOR  = 64'hD8,
    parameter int             SYNC_STAGES = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_ext_irq,
    input  logic         i_instr_valid,
    input  logic         i_not_an_instr,
    input  logic         i_eret,
    input  logic [N-1:0] i_pc_d,
    output logic         o_redirect,
    output logic [N-1:0] o_redirect_pc,
    output logic         o_flush,
    output logic [N-1:0] o_elr,
    output logic [3:0]   o_esr,
    output logic         o_in_handler,
    output logic         o_irq_ack,
    output logic         o_halted
);
    typedef enum logic [2:0] {S_RUN, S_TAKE, S_HANDLER, S_RETURN, S_HALT} state_t;

    state_t                 r_state, w_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_irq_prev, r_irq_pend;
    logic [N-1:0]           r_elr;
    logic [3:0]             r_esr;
    logic                   w_rise, w_take_irq, w_take_bad, w_ret;

    assign w_rise     = r_sync[SYNC_STAGES-1] & ~r_irq_prev;
    assign w_take_irq = (r_state == S_RUN) && i_instr_valid && r_irq_pend;
    // An ERET outside a handler is treated as an invalid opcode.
    assign w_take_bad = (r_state == S_RUN) && i_instr_valid && !r_irq_pend && (i_not_an_instr || i_eret);
    assign w_ret      = (r_state == S_HANDLER) && (w_next == S_RETURN);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RUN:     w_next = (w_take_irq || w_take_bad) ? S_TAKE : S_RUN;
            S_TAKE:    w_next = S_HANDLER;
            S_HANDLER: w_next = (i_instr_valid && i_not_an_instr) ? S_HALT :
                                (i_instr_valid && i_eret) ? S_RETURN : S_HANDLER;
            S_RETURN:  w_next = S_RUN;
            S_HALT:    w_next = S_HALT;
            default:   w_next = S_RUN;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_RUN;
            r_sync     <= '0;
            r_irq_prev <= 1'b0;
            r_irq_pend <= 1'b0;
            r_elr      <= '0;
            r_esr      <= 4'b0000;
        end else begin
            r_state    <= w_next;
            r_sync     <= {r_sync[SYNC_STAGES-2:0], i_ext_irq};
            r_irq_prev <= r_sync[SYNC_STAGES-1];
            r_irq_pend <= w_rise | (r_irq_pend & ~w_take_irq);
            if (w_take_irq || w_take_bad) begin
                r_elr <= i_pc_d;
                r_esr <= w_take_irq ? 4'b0001 : 4'b0010;
            end else if (w_ret) begin
                r_esr <= 4'b0000;
            end
        end
    end

    assign o_redirect    = (r_state == S_TAKE) || (r_state == S_RETURN);
    assign o_flush       = o_redirect;
    assign o_redirect_pc = (r_state == S_TAKE) ? EXC_VECTOR : (r_state == S_RETURN) ? r_elr : '0;
    assign o_irq_ack     = (r_state == S_TAKE) && (r_esr == 4'b0001);
    assign o_in_handler  = (r_state == S_HANDLER);
    assign o_halted      = (r_state == S_HALT);
    assign o_elr         = r_elr;
    assign o_esr         = r_esr;
endmodule
